// File: rtl/aes_byte_loader_pkg.sv
// ----------------------------------------------------------------------------
// aes_byte_loader_pkg
// Shared definitions for the AES byte loader and its output serialiser.
//   state_t        FSM state encoding (exposed on the loader's dbg_state port)
//   HDR_*          bit positions inside the frame header byte
//   BLOCK_BYTES    bytes per 128-bit AES block
//   shift_in_byte  appends one byte at the LSB end, so that the first of
//                  16 bytes ends up in bits [127:120]
// ----------------------------------------------------------------------------
package aes_byte_loader_pkg;

  localparam int BLOCK_BYTES = 16;

  // Header byte layout; bits [7:3] carry nothing.
  localparam int HDR_DEC    = 0;
  localparam int HDR_NEWKEY = 1;
  localparam int HDR_IV     = 2;

  localparam logic [3:0] LAST_BYTE_IDX = 4'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_IV    = 3'd2,
    S_TEXT  = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_SEND  = 3'd6
  } state_t;

  function automatic logic [127:0] shift_in_byte(input logic [127:0] cur,
                                                 input logic [7:0]   b);
    return {cur[119:0], b};
  endfunction

endpackage

// File: rtl/aes_byte_loader_ser.sv
// ----------------------------------------------------------------------------
// aes_byte_ser
// 128-bit load-and-shift register that streams a block out MSB-first, one
// byte per accepted handshake.
//
// Handshake: a byte moves on every rising clk edge where tx_vld and tx_rdy
// are both high; while tx_rdy is low, tx_byte and tx_vld hold their values.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   load       one-cycle pulse: capture data and start streaming
//   data       block to stream (bits [127:120] go out first)
//   tx_byte    current output byte
//   tx_vld     high while bytes remain
//   tx_rdy     downstream ready
//   done       high on the cycle the 16th byte is accepted
// ----------------------------------------------------------------------------
module aes_byte_ser
  import aes_byte_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] data,
  output logic [7:0]   tx_byte,
  output logic         tx_vld,
  input  logic         tx_rdy,
  output logic         done
);

  logic [127:0] shreg;
  logic [3:0]   cnt;
  logic         active;
  logic         fire;
  logic         cnt_last;

  assign fire     = active & tx_rdy;
  assign cnt_last = (cnt == LAST_BYTE_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= data;
      cnt    <= '0;
      active <= 1'b1;
    end else if (fire) begin
      // Zero-fill keeps tx_byte at 0x00 once the block has drained.
      shreg <= {shreg[119:0], 8'h00};
      cnt   <= cnt + 4'd1;
      if (cnt_last) begin
        active <= 1'b0;
      end
    end
  end

  assign tx_byte = shreg[127:120];
  assign tx_vld  = active;
  assign done    = fire & cnt_last;

endmodule

// File: rtl/aes_byte_loader.sv
// ----------------------------------------------------------------------------
// aes_byte_loader
// Byte-stream front end for a 128-bit AES core. A host frame is a header
// byte followed by an optional 16-byte key, an optional 16-byte IV (CBC
// builds only) and a 16-byte text block. The block is handed to the core
// with a one-cycle start pulse, the result is captured on i_fDone and
// streamed back MSB-first.
//
// Header: bit0 decrypt, bit1 new key, bit2 load IV, bits[7:3] ignored.
// A key phase is forced whenever no key has been loaded since reset.
//
// Build option: define AES_LOADER_CBC_EN to add the 128-bit chain register
// and the IV phase (CBC mode). Without it the block runs ECB only and header
// bit2 has no effect.
//
// Handshake (both byte streams): a byte moves on every rising i_Clk edge
// where the stream's valid and ready are both high.
//
// Ports
//   i_Clk, i_Rst              clock, asynchronous active-high reset
//   i_Byte/i_fByteVld/o_fByteRdy   host -> loader byte stream
//   o_Byte/o_fByteVld/i_fByteRdy   loader -> host byte stream
//   o_fStart, o_fDec, o_Text, o_Key   request to the AES core
//   i_Data, i_fDone           result from the AES core
//   o_fBusy                   high whenever the FSM is not in IDLE
//   dbg_state                 current FSM state (state_t encoding)
// ----------------------------------------------------------------------------
module aes_byte_loader
  import aes_byte_loader_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [7:0]   i_Byte,
  input  logic         i_fByteVld,
  output logic         o_fByteRdy,
  output logic [7:0]   o_Byte,
  output logic         o_fByteVld,
  input  logic         i_fByteRdy,
  output logic         o_fStart,
  output logic         o_fDec,
  output logic [127:0] o_Text,
  output logic [127:0] o_Key,
  input  logic [127:0] i_Data,
  input  logic         i_fDone,
  output logic         o_fBusy,
  output logic [2:0]   dbg_state
);

  state_t       state;
  state_t       state_nxt;

  logic [3:0]   cnt;
  logic         cnt_last;
  logic         key_vld;
  logic         dec_q;
  logic [127:0] key_q;
  logic [127:0] text_q;

  logic         accept_state;
  logic         byte_rdy;
  logic         in_fire;
  logic         capture;
  logic [127:0] result;
  logic         ser_done;

`ifdef AES_LOADER_CBC_EN
  logic [127:0] chain_q;
  logic         iv_pend;
`endif

  // --------------------------------------------------------------------------
  // Input handshake
  // --------------------------------------------------------------------------
  assign accept_state = (state == S_IDLE) || (state == S_KEY) ||
                        (state == S_IV)   || (state == S_TEXT);
  // The FSM already sits in IDLE during reset; gating with i_Rst keeps the
  // host from seeing ready until reset has been released.
  assign byte_rdy     = accept_state & ~i_Rst;
  assign in_fire      = i_fByteVld & byte_rdy;
  assign cnt_last     = (cnt == LAST_BYTE_IDX);
  assign capture      = (state == S_WAIT) & i_fDone;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    o_fStart  = 1'b0;
    o_fBusy   = 1'b1;

    case (state)
      S_IDLE: begin
        o_fBusy = 1'b0;
        if (in_fire) begin
          if (i_Byte[HDR_NEWKEY] || !key_vld) begin
            state_nxt = S_KEY;
          end
`ifdef AES_LOADER_CBC_EN
          else if (i_Byte[HDR_IV]) begin
            state_nxt = S_IV;
          end
`endif
          else begin
            state_nxt = S_TEXT;
          end
        end
      end

      S_KEY: begin
        if (in_fire && cnt_last) begin
`ifdef AES_LOADER_CBC_EN
          state_nxt = iv_pend ? S_IV : S_TEXT;
`else
          state_nxt = S_TEXT;
`endif
        end
      end

`ifdef AES_LOADER_CBC_EN
      S_IV: begin
        if (in_fire && cnt_last) begin
          state_nxt = S_TEXT;
        end
      end
`endif

      S_TEXT: begin
        if (in_fire && cnt_last) begin
          state_nxt = S_START;
        end
      end

      S_START: begin
        o_fStart  = 1'b1;
        state_nxt = S_WAIT;
      end

      // No timeout: the core is trusted to eventually raise i_fDone.
      S_WAIT: begin
        if (i_fDone) begin
          state_nxt = S_SEND;
        end
      end

      S_SEND: begin
        if (ser_done) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame datapath: byte counter, key, text, header flags, chain
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt     <= '0;
      key_vld <= 1'b0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      text_q  <= '0;
`ifdef AES_LOADER_CBC_EN
      chain_q <= '0;
      iv_pend <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        // The 4-bit counter only runs inside the 16-byte phases, so it
        // naturally wraps 15 -> 0 as each phase is left.
        if (state != S_IDLE) begin
          cnt <= cnt + 4'd1;
        end

        case (state)
          S_IDLE: begin
            dec_q <= i_Byte[HDR_DEC];
`ifdef AES_LOADER_CBC_EN
            iv_pend <= i_Byte[HDR_IV];
`endif
          end

          S_KEY: begin
            key_q <= shift_in_byte(key_q, i_Byte);
            if (cnt_last) begin
              key_vld <= 1'b1;
            end
          end

`ifdef AES_LOADER_CBC_EN
          S_IV: begin
            chain_q <= shift_in_byte(chain_q, i_Byte);
          end

          S_TEXT: begin
            // Encrypt folds the chain in on the last byte so o_Text is
            // already plaintext ^ chain, and registered, at START.
            if (cnt_last && !dec_q) begin
              text_q <= shift_in_byte(text_q, i_Byte) ^ chain_q;
            end else begin
              text_q <= shift_in_byte(text_q, i_Byte);
            end
          end
`else
          S_TEXT: begin
            text_q <= shift_in_byte(text_q, i_Byte);
          end
`endif

          default: begin
          end
        endcase
      end

`ifdef AES_LOADER_CBC_EN
      // Encrypt chains on the new ciphertext; decrypt chains on the
      // ciphertext just received, which text_q still holds unmodified.
      if (capture) begin
        chain_q <= dec_q ? text_q : i_Data;
      end
`endif
    end
  end

`ifdef AES_LOADER_CBC_EN
  assign result = dec_q ? (i_Data ^ chain_q) : i_Data;
`else
  assign result = i_Data;
`endif

  // --------------------------------------------------------------------------
  // Output serialiser
  // --------------------------------------------------------------------------
  aes_byte_ser u_ser (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .load    (capture),
    .data    (result),
    .tx_byte (o_Byte),
    .tx_vld  (o_fByteVld),
    .tx_rdy  (i_fByteRdy),
    .done    (ser_done)
  );

  assign o_fByteRdy = byte_rdy;
  assign o_fDec     = dec_q;
  assign o_Text     = text_q;
  assign o_Key      = key_q;
  assign dbg_state  = state;

endmodule
